branch_history_table: RTL

- Dynamic branch predictor for the fetch stage.
- Each entry is a 2-bit saturating counter, indexed by PC; the fetch stage reads a taken/not-taken prediction.
- The execute stage writes back the resolved outcome (the branch comparator's compare_result) together with the prediction that was used.
- The block registers a mispredict pulse and keeps branch/mispredict statistics.
- A clear FSM initialises the table after reset or on request.

---
 rtl/bht_pkg.sv | 9 +
 rtl/branch_history_table_if.sv | 11 +
 rtl/bht_sat_counter.sv | 11 +
 rtl/branch_history_table.sv | 56 +++++
 4 files changed

// File: rtl/bht_pkg.sv
// bht_pkg: shared counter encodings and FSM state for the branch history table
package bht_pkg;
  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT = 2'b10;
  localparam logic [1:0] CNT_ST = 2'b11;
  localparam logic [1:0] CNT_INIT = CNT_WNT;
  typedef enum logic {INIT, READY} bht_state_t;
endpackage

// File: rtl/branch_history_table_if.sv
// branch_history_table_if: fetch-side predict and execute-side update signals
interface branch_history_table_if #(parameter int PC_WIDTH = 32);
  logic [PC_WIDTH-1:0] pred_pc;
  logic pred_taken;
  logic upd_valid;
  logic [PC_WIDTH-1:0] upd_pc;
  logic upd_taken;
  logic upd_pred_taken;
  modport master(output pred_pc, upd_valid, upd_pc, upd_taken, upd_pred_taken, input pred_taken);
  modport slave(input pred_pc, upd_valid, upd_pc, upd_taken, upd_pred_taken, output pred_taken);
endinterface

// File: rtl/bht_sat_counter.sv
// bht_sat_counter: next value of a 2-bit saturating branch counter
module bht_sat_counter
  import bht_pkg::*;
(
  input logic [1:0] cur,
  input logic taken,
  output logic [1:0] nxt
);
  always_comb nxt = taken ? ((cur == CNT_ST) ? cur : cur + 2'd1)
                          : ((cur == CNT_SNT) ? cur : cur - 2'd1);
endmodule

// File: rtl/branch_history_table.sv
// branch_history_table: 2-bit counter branch predictor with clear sweep and statistics
module branch_history_table
  import bht_pkg::*;
#(
  parameter int INDEX_WIDTH = 6,
  parameter int PC_WIDTH = 32,
  parameter int STAT_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  branch_history_table_if.slave bus,
  input logic clear,
  output logic init_busy,
  output logic mispredict,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);
  logic [1:0] cnt_mem [2**INDEX_WIDTH];
  bht_state_t state;
  logic [INDEX_WIDTH-1:0] init_idx, pred_idx, upd_idx;
  logic [1:0] nxt;
  logic accept, miss, unused_bits;
  assign pred_idx = bus.pred_pc[INDEX_WIDTH+1:2];
  assign upd_idx = bus.upd_pc[INDEX_WIDTH+1:2];
  assign unused_bits = ^{bus.pred_pc[PC_WIDTH-1:INDEX_WIDTH+2], bus.pred_pc[1:0],
                         bus.upd_pc[PC_WIDTH-1:INDEX_WIDTH+2], bus.upd_pc[1:0]};
  assign accept = rst_n && state == READY && bus.upd_valid;
  assign miss = accept && (bus.upd_taken != bus.upd_pred_taken);
  assign init_busy = state == INIT;
  // Read is the pre-edge value: a same-index update is not bypassed
  assign bus.pred_taken = rst_n && state == READY && cnt_mem[pred_idx][1];
  bht_sat_counter u_sat (.cur(cnt_mem[upd_idx]), .taken(bus.upd_taken), .nxt(nxt));
  always_ff @(posedge clk)
    if (rst_n && state == INIT) cnt_mem[init_idx] <= CNT_INIT;
    else if (accept) cnt_mem[upd_idx] <= nxt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
      init_idx <= '0;
      mispredict <= 1'b0;
      stat_branches <= '0;
      stat_mispredicts <= '0;
    end else begin
      mispredict <= miss;
      if (accept && !(&stat_branches)) stat_branches <= stat_branches + STAT_WIDTH'(1);
      if (miss && !(&stat_mispredicts)) stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
      if (state == INIT) begin
        init_idx <= init_idx + INDEX_WIDTH'(1);
        if (init_idx == '1) state <= READY;
      end else if (clear) begin
        state <= INIT;
        init_idx <= '0;
      end
    end
  end
endmodule
